ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- Execute→memory boundary register of core_lapido; sits directly downstream of the ALU.
- Captures alu_res, with bit 32 as carry, plus the ALU flags and the memory/write-back control for the instruction.
- Holds the architectural flag register.
- Evaluates flag-conditional jumps (jt/jf) against that flag register, producing a registered branch_taken for the fetch stage.

Parameters:
- DATA_W, 32, datapath width; alu_res is DATA_W+1 bits.
- RADDR_W, 5, register-file address width.
- FLAG_W, 5, ALU flag bus width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX holds a valid instruction.
- stall  in  1  hold all registered state.
- flush  in  1  squash the instruction being captured.
- alu_res  in  DATA_W+1  ALU result; [DATA_W] is carry.
- flags  in  FLAG_W  [0] zero, [1] neg, [2] overflow, [3] negzero, [4] true.
- set_flags  in  1  instruction updates the flag register.
- cond_check  in  1  instruction is jt/jf.
- cond_pol  in  1  1 = jt (jump if condition true), 0 = jf.
- cond_sel  in  3  0 true, 1 zero, 2 neg, 3 negzero, 4 carry, 5 overflow, 6-7 reserved.
- rd_addr  in  RADDR_W  destination register.
- reg_write, mem_read, mem_write  in  1 each  control bits.
- store_data  in  DATA_W  rt value for stores.
- out_valid  out  1  MEM-stage valid.
- out_alu_res  out  DATA_W  result, carry stripped.
- out_rd_addr  out  RADDR_W  registered rd_addr.
- out_reg_write, out_mem_read, out_mem_write  out  1 each  registered control bits.
- out_store_data  out  DATA_W  registered store_data.
- flag_reg  out  6  {overflow, carry, negzero, neg, zero, true}.
- branch_taken  out  1  registered flag-jump decision.

Behaviour:
- Reset (rst_n low, asynchronous): every output and internal register goes to 0, including flag_reg.
  - Flag bit 0 ("true") is forced to 1 immediately after reset and always.
  - Reset mid-stall or mid-flush returns the block to reset state; after release it resumes normal capture at the next edge.
- Latency: one cycle. Inputs present at edge N appear on out_* after edge N.
- Priority per edge: rst_n > flush > stall > capture.
- flush=1 (with or without stall):
  - out_valid, out_reg_write, out_mem_read, out_mem_write, branch_taken go to 0.
  - out_alu_res, out_rd_addr, out_store_data hold their previous values.
  - flag_reg is not updated.
- stall=1, flush=0: all outputs and flag_reg hold. Combinational inputs are ignored.
- Capture (stall=0, flush=0):
  - out_valid <= in_valid.
  - Control outputs <= respective inputs AND in_valid; they must never assert with out_valid=0.
  - Data outputs <= inputs unconditionally.
- Flag update: on capture with in_valid & set_flags, flag_reg <= {flags[2], alu_res[DATA_W], flags[3], flags[1], flags[0], 1'b1}.
- Condition evaluation:
  - cond = flag_reg bit selected by cond_sel, using the value before this edge's update.
  - Map: 0→bit0, 1→bit1, 2→bit2, 3→bit3, 4→bit4, 5→bit5.
  - On capture: branch_taken <= in_valid & cond_check & (cond_sel<6) & (cond == cond_pol).
  - Reserved cond_sel never takes, for both jt and jf.
- Simultaneous set_flags and cond_check in one instruction: the condition uses old flags; the flag register updates in the same edge.
- Back-to-back case: a flag-setting instruction at edge N followed by a jt at edge N+1 sees the new flags. There is no hazard inside this block.
- No arithmetic is performed here. Carry is taken solely from alu_res[DATA_W], never recomputed.

Decomposition:
- Shared package lapido_pkg holds:
  - cond_sel codes: COND_TRUE..COND_OVF.
  - Flag bit index constants for both flags and flag_reg.
  - FN_* ALU function codes, already shared with the alu.
- One combinational sub-module, cond_eval: inputs flag_reg, cond_sel, cond_pol; output take. It is reused by the branch-prediction checker.

Test Plan:
- Reset: hold rst_n=0 with random inputs → all outputs 0 except flag_reg=6'b000001. Release → the first capture is clean.
- ADD 2+1, set_flags=1, rd=5, reg_write=1 → next cycle out_alu_res=3, out_rd_addr=5, out_reg_write=1, flag_reg=6'b000001.
- SUB 1-1 (alu_res=33'h1_00000000, flags=5'b11001), set_flags, then jt cond_sel=1 → flag_reg=6'b011011; next cycle branch_taken=1. The same jf gives branch_taken=0.
- Single instruction with set_flags=1, cond_check=1, cond_sel=4 and carry=1 into flag_reg whose carry is 0 → branch_taken=0 (old flags used); flag_reg carry becomes 1.
- stall held 3 cycles while inputs change → outputs frozen. flush with stall=1 → out_valid=0, controls 0, flag_reg unchanged.
- cond_sel=6 and cond_sel=7 with cond_pol 0 and 1 → branch_taken=0 in all four cases. in_valid=0 with mem_write=1 → out_mem_write=0.

Source files
------------

// File: rtl/lapido_pkg.sv
// Shared core_lapido definitions: condition codes, flag bit positions,
// ALU function codes and the EX/MEM control bundle.
package lapido_pkg;

    localparam int FR_W = 6;

    typedef enum logic [2:0] {
        COND_TRUE  = 3'd0,
        COND_ZERO  = 3'd1,
        COND_NEG   = 3'd2,
        COND_NZ    = 3'd3,
        COND_CARRY = 3'd4,
        COND_OVF   = 3'd5
    } cond_e;

    // Bit positions on the ALU flag bus
    localparam int FL_ZERO = 0;
    localparam int FL_NEG  = 1;
    localparam int FL_OVF  = 2;
    localparam int FL_NZ   = 3;
    localparam int FL_TRUE = 4;

    // Bit positions in the architectural flag register
    localparam int FR_TRUE  = 0;
    localparam int FR_ZERO  = 1;
    localparam int FR_NEG   = 2;
    localparam int FR_NZ    = 3;
    localparam int FR_CARRY = 4;
    localparam int FR_OVF   = 5;

    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_AND  = 4'd2,
        FN_OR   = 4'd3,
        FN_XOR  = 4'd4,
        FN_SHL  = 4'd5,
        FN_SHR  = 4'd6,
        FN_PASS = 4'd7
    } alu_fn_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX->MEM boundary bundle; master is the EX/hazard side,
// slave is the boundary register itself.
interface ex_mem_reg_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int FLAG_W  = 5
);
    logic               in_valid;
    logic               stall;
    logic               flush;
    logic [DATA_W:0]    alu_res;
    logic [FLAG_W-1:0]  flags;
    logic               set_flags;
    logic               cond_check;
    logic               cond_pol;
    logic [2:0]         cond_sel;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [DATA_W-1:0]  store_data;

    logic               out_valid;
    logic [DATA_W-1:0]  out_alu_res;
    logic [RADDR_W-1:0] out_rd_addr;
    logic               out_reg_write;
    logic               out_mem_read;
    logic               out_mem_write;
    logic [DATA_W-1:0]  out_store_data;
    logic [5:0]         flag_reg;
    logic               branch_taken;

    modport master (
        output in_valid, stall, flush, alu_res, flags,
        output set_flags, cond_check, cond_pol, cond_sel,
        output rd_addr, reg_write, mem_read, mem_write,
        output store_data,
        input  out_valid, out_alu_res, out_rd_addr,
        input  out_reg_write, out_mem_read, out_mem_write,
        input  out_store_data, flag_reg, branch_taken
    );

    modport slave (
        input  in_valid, stall, flush, alu_res, flags,
        input  set_flags, cond_check, cond_pol, cond_sel,
        input  rd_addr, reg_write, mem_read, mem_write,
        input  store_data,
        output out_valid, out_alu_res, out_rd_addr,
        output out_reg_write, out_mem_read, out_mem_write,
        output out_store_data, flag_reg, branch_taken
    );
endinterface

// File: rtl/ex_mem_reg_cond_eval.sv
// Flag-conditional jump evaluator; also used by the
// branch-prediction checker.
module cond_eval
    import lapido_pkg::*;
(
    input  logic [FR_W-1:0] flag_reg,
    input  logic [2:0]      cond_sel,
    input  logic            cond_pol,
    output logic            take
);
    logic w_cond;
    logic w_legal;

    always_comb begin
        w_cond  = 1'b0;
        w_legal = 1'b1;
        unique case (cond_sel)
            COND_TRUE:  w_cond = flag_reg[FR_TRUE];
            COND_ZERO:  w_cond = flag_reg[FR_ZERO];
            COND_NEG:   w_cond = flag_reg[FR_NEG];
            COND_NZ:    w_cond = flag_reg[FR_NZ];
            COND_CARRY: w_cond = flag_reg[FR_CARRY];
            COND_OVF:   w_cond = flag_reg[FR_OVF];
            default:    w_legal = 1'b0;
        endcase
    end

    // Reserved selectors never take, whichever polarity is asked for
    assign take = w_legal & (w_cond == cond_pol);
endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM boundary register: captures ALU result and controls,
// owns the flag register and resolves jt/jf.
module ex_mem_reg
    import lapido_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int FLAG_W  = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_mem_reg_if.slave  bus
);
    logic               r_valid;
    mem_ctrl_t          r_ctrl;
    logic [DATA_W-1:0]  r_alu;
    logic [RADDR_W-1:0] r_rd;
    logic [DATA_W-1:0]  r_sd;
    logic [FR_W-1:1]    r_fl;
    logic               r_bt;

    logic [FR_W-1:0]    w_flag_reg;
    logic [FLAG_W-1:0]  w_flags;
    logic               w_take;
    logic               w_unused;

    // The "true" flag is architecturally constant, so it is not stored
    assign w_flag_reg = {r_fl, 1'b1};
    assign w_flags    = bus.flags;
    assign w_unused   = w_flags[FL_TRUE];

    cond_eval u_cond (
        .flag_reg (w_flag_reg),
        .cond_sel (bus.cond_sel),
        .cond_pol (bus.cond_pol),
        .take     (w_take)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_alu   <= '0;
            r_rd    <= '0;
            r_sd    <= '0;
            r_fl    <= '0;
            r_bt    <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_bt    <= 1'b0;
        end else if (!bus.stall) begin
            r_valid          <= bus.in_valid;
            r_ctrl.reg_write <= bus.reg_write & bus.in_valid;
            r_ctrl.mem_read  <= bus.mem_read  & bus.in_valid;
            r_ctrl.mem_write <= bus.mem_write & bus.in_valid;
            r_alu            <= bus.alu_res[DATA_W-1:0];
            r_rd             <= bus.rd_addr;
            r_sd             <= bus.store_data;
            r_bt             <= bus.in_valid & bus.cond_check & w_take;
            // Condition above sees the pre-update flags
            if (bus.in_valid && bus.set_flags) begin
                r_fl <= {w_flags[FL_OVF],
                         bus.alu_res[DATA_W],
                         w_flags[FL_NZ],
                         w_flags[FL_NEG],
                         w_flags[FL_ZERO]};
            end
        end
    end

    assign bus.out_valid      = r_valid;
    assign bus.out_alu_res    = r_alu;
    assign bus.out_rd_addr    = r_rd;
    assign bus.out_reg_write  = r_ctrl.reg_write;
    assign bus.out_mem_read   = r_ctrl.mem_read;
    assign bus.out_mem_write  = r_ctrl.mem_write;
    assign bus.out_store_data = r_sd;
    assign bus.flag_reg       = w_flag_reg;
    assign bus.branch_taken   = r_bt;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomised bench for ex_mem_reg against a behavioural model,
// plus directed literal checks.
module tb_ex_mem_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_mem_reg_if bus ();

    ex_mem_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    bit          m_valid, m_rw, m_mr, m_mw, m_bt;
    logic [31:0] m_alu, m_sd;
    logic [4:0]  m_rd;
    logic [5:0]  m_fr;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_bt = 0;
        m_alu = '0; m_sd = '0; m_rd = '0;
        m_fr = 6'b000001;
    endtask

    // Flag register layout: {ovf, carry, negzero, neg, zero, true}
    task automatic model_step();
        bit [5:0] nf;
        bit       cond;
        int       sel;
        if (!rst_n) begin
            model_reset();
        end else if (bus.flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_bt = 0;
        end else if (!bus.stall) begin
            sel  = int'(bus.cond_sel);
            cond = (sel < 6) ? m_fr[sel] : 1'b0;
            m_bt = bus.in_valid && bus.cond_check && (sel < 6)
                   && (cond == bus.cond_pol);
            m_valid = bus.in_valid;
            m_rw  = bus.in_valid && bus.reg_write;
            m_mr  = bus.in_valid && bus.mem_read;
            m_mw  = bus.in_valid && bus.mem_write;
            m_alu = bus.alu_res[31:0];
            m_rd  = bus.rd_addr;
            m_sd  = bus.store_data;
            if (bus.in_valid && bus.set_flags) begin
                nf[0] = 1'b1;
                nf[1] = bus.flags[0];
                nf[2] = bus.flags[1];
                nf[3] = bus.flags[3];
                nf[4] = bus.alu_res[32];
                nf[5] = bus.flags[2];
                m_fr  = nf;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", 64'(bus.out_valid),      64'(m_valid));
            chk("alu",   64'(bus.out_alu_res),    64'(m_alu));
            chk("rd",    64'(bus.out_rd_addr),    64'(m_rd));
            chk("rw",    64'(bus.out_reg_write),  64'(m_rw));
            chk("mr",    64'(bus.out_mem_read),   64'(m_mr));
            chk("mw",    64'(bus.out_mem_write),  64'(m_mw));
            chk("sd",    64'(bus.out_store_data), 64'(m_sd));
            chk("fr",    64'(bus.flag_reg),       64'(m_fr));
            chk("bt",    64'(bus.branch_taken),   64'(m_bt));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        bus.stall      = ($urandom_range(0, 4) == 0);
        bus.flush      = ($urandom_range(0, 9) == 0);
        bus.in_valid   = ($urandom_range(0, 3) != 0);
        bus.alu_res    = {1'($urandom_range(0, 1)), 32'($urandom)};
        bus.flags      = 5'($urandom);
        bus.set_flags  = 1'($urandom);
        bus.cond_check = 1'($urandom);
        bus.cond_pol   = 1'($urandom);
        bus.cond_sel   = 3'($urandom);
        bus.rd_addr    = 5'($urandom);
        bus.reg_write  = 1'($urandom);
        bus.mem_read   = 1'($urandom);
        bus.mem_write  = 1'($urandom);
        bus.store_data = 32'($urandom);
    endtask

    task automatic set_in(bit v, logic [32:0] res, logic [4:0] fl,
                          bit sf, bit cc, bit pol, logic [2:0] sel,
                          logic [4:0] rd, bit rw, bit mr, bit mw,
                          logic [31:0] sd);
        bus.stall = 0; bus.flush = 0;
        bus.in_valid = v; bus.alu_res = res; bus.flags = fl;
        bus.set_flags = sf; bus.cond_check = cc;
        bus.cond_pol = pol; bus.cond_sel = sel;
        bus.rd_addr = rd; bus.reg_write = rw;
        bus.mem_read = mr; bus.mem_write = mw;
        bus.store_data = sd;
    endtask

    initial begin
        rst_n = 0;
        rand_inputs();
        model_reset();
        cmp_en = 1;
        repeat (3) tick();
        chk("rst_valid", 64'(bus.out_valid), 0);
        chk("rst_fr",    64'(bus.flag_reg), 64'b000001);
        chk("rst_alu",   64'(bus.out_alu_res), 0);
        chk("rst_bt",    64'(bus.branch_taken), 0);
        chk("rst_mw",    64'(bus.out_mem_write), 0);
        #2 rst_n = 1;

        // ADD 2+1 -> 3
        set_in(1, 33'd3, 5'b10000, 1, 0, 0, 3'd0, 5'd5, 1, 0, 0, 32'd0);
        tick();
        chk("add_valid", 64'(bus.out_valid), 1);
        chk("add_alu",   64'(bus.out_alu_res), 3);
        chk("add_rd",    64'(bus.out_rd_addr), 5);
        chk("add_rw",    64'(bus.out_reg_write), 1);
        chk("add_fr",    64'(bus.flag_reg), 64'b000001);

        // SUB 1-1 then jt/jf on zero
        set_in(1, 33'h1_0000_0000, 5'b11001, 1, 0, 0, 3'd0, 5'd1, 1, 0, 0, 32'd0);
        tick();
        chk("sub_fr", 64'(bus.flag_reg), 64'b011011);
        set_in(1, 33'd0, 5'd0, 0, 1, 1, 3'd1, 5'd0, 0, 0, 0, 32'd0);
        tick();
        chk("jt_zero", 64'(bus.branch_taken), 1);
        set_in(1, 33'd0, 5'd0, 0, 1, 0, 3'd1, 5'd0, 0, 0, 0, 32'd0);
        tick();
        chk("jf_zero", 64'(bus.branch_taken), 0);

        // Clear carry, then set_flags + jt carry in one instruction
        set_in(1, 33'd0, 5'b10000, 1, 0, 0, 3'd0, 5'd0, 0, 0, 0, 32'd0);
        tick();
        chk("clr_fr", 64'(bus.flag_reg), 64'b000001);
        set_in(1, 33'h1_0000_0007, 5'b10000, 1, 1, 1, 3'd4, 5'd0, 0, 0, 0, 32'd0);
        tick();
        chk("old_flags_bt", 64'(bus.branch_taken), 0);
        chk("carry_fr",     64'(bus.flag_reg), 64'b010001);

        // Stall: outputs frozen while inputs change
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            bus.stall = 1; bus.flush = 0;
            tick();
            chk("stall_valid", 64'(bus.out_valid), 1);
            chk("stall_alu",   64'(bus.out_alu_res), 7);
            chk("stall_fr",    64'(bus.flag_reg), 64'b010001);
        end
        rand_inputs();
        bus.stall = 1; bus.flush = 1;
        bus.in_valid = 1; bus.set_flags = 1; bus.reg_write = 1;
        tick();
        chk("flush_valid", 64'(bus.out_valid), 0);
        chk("flush_rw",    64'(bus.out_reg_write), 0);
        chk("flush_fr",    64'(bus.flag_reg), 64'b010001);
        chk("flush_alu",   64'(bus.out_alu_res), 7);

        // Reserved selectors never take
        for (int s = 6; s < 8; s++) begin
            for (int p = 0; p < 2; p++) begin
                set_in(1, 33'd0, 5'd0, 0, 1, 1'(p), 3'(s), 5'd0, 0, 0, 0, 32'd0);
                tick();
                chk("rsv_bt", 64'(bus.branch_taken), 0);
            end
        end

        set_in(0, 33'd9, 5'd0, 0, 0, 0, 3'd0, 5'd3, 1, 1, 1, 32'hdead);
        tick();
        chk("inv_mw",    64'(bus.out_mem_write), 0);
        chk("inv_valid", 64'(bus.out_valid), 0);

        // Randomised run including occasional reset mid-stall/flush
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 0;
                model_reset();
                tick();
                chk("midrst_fr", 64'(bus.flag_reg), 64'b000001);
                #2 rst_n = 1;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
